// File: rtl/riscv_gprs_read.sv
// riscv_gprs_read: 32 x XLEN GPR array with bypassed registered read ports and a handshaked dump stream
module riscv_gprs_read #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_write_en,
  input  logic [AW-1:0]   reg_write_dest,
  input  logic [XLEN-1:0] reg_write_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr_1,
  input  logic [AW-1:0]   rd_addr_2,
  output logic [XLEN-1:0] rd_data_1,
  output logic [XLEN-1:0] rd_data_2,
  input  logic            dump_start,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [AW-1:0]   dump_addr,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_busy,
  output logic            dump_done
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t r_state, w_next;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [XLEN-1:0] r_rd_data_1, r_rd_data_2, r_dump_data;
  logic [AW-1:0] r_dump_addr, w_naddr;
  logic w_we, w_accept, w_last;
  function automatic logic [XLEN-1:0] rd_byp(input logic [AW-1:0] a);
    return a == '0 ? '0 : (w_we && reg_write_dest == a) ? reg_write_data : r_regs[a];
  endfunction
  assign w_we     = reg_write_en && reg_write_dest != '0;
  assign w_last   = r_dump_addr == AW'(NREGS - 1);
  assign w_accept = r_state == STREAM && dump_ready;
  assign w_naddr  = r_dump_addr + AW'(1);
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE   ? (dump_start ? STREAM : IDLE) :
             r_state == STREAM ? (w_accept && w_last ? DONE : STREAM) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rd_data_1 <= '0;
      r_rd_data_2 <= '0;
      r_dump_addr <= '0;
      r_dump_data <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_we) r_regs[reg_write_dest] <= reg_write_data;
      if (rd_en) begin
        r_rd_data_1 <= rd_byp(rd_addr_1);
        r_rd_data_2 <= rd_byp(rd_addr_2);
      end
      if (r_state == IDLE && dump_start) begin
        r_dump_addr <= '0;
        r_dump_data <= '0;
      end else if (w_accept && !w_last) begin
        r_dump_addr <= w_naddr;
        r_dump_data <= rd_byp(w_naddr);
      end
    end
  end
  assign rd_data_1  = r_rd_data_1;
  assign rd_data_2  = r_rd_data_2;
  assign dump_addr  = r_dump_addr;
  assign dump_data  = r_dump_data;
  assign dump_valid = r_state == STREAM;
  assign dump_busy  = r_state != IDLE;
  assign dump_done  = r_state == DONE;
endmodule

// File: tb/tb_riscv_gprs_read.sv
// tb_riscv_gprs_read: scoreboard bench for the GPR read ports and dump stream
module tb_riscv_gprs_read;
  logic clk = 0, rst = 1;
  logic reg_write_en = 0, rd_en = 0, dump_start = 0, dump_ready = 0;
  logic [4:0] reg_write_dest = 0, rd_addr_1 = 0, rd_addr_2 = 0, dump_addr;
  logic [31:0] reg_write_data = 0, rd_data_1, rd_data_2, dump_data;
  logic dump_valid, dump_busy, dump_done;
  logic rd_seen = 0;
  logic [63:0] rq[$];
  logic [36:0] dq[$];
  int checks = 0, errors = 0, cyc = 0, acc = 0, done_cnt = 0, done_cyc = 0, first_acc = 0, last_acc = 0;
  int stall, hit, acc0, dc0;
  riscv_gprs_read dut (
    .clk(clk), .rst(rst), .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2), .dump_start(dump_start), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy),
    .dump_done(dump_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_write_en = 1; reg_write_dest = a; reg_write_data = d;
    step();
    reg_write_en = 0;
  endtask
  task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] e1, input logic [31:0] e2);
    rd_en = 1; rd_addr_1 = a1; rd_addr_2 = a2;
    rq.push_back({e1, e2});
    step();
    rd_en = 0;
  endtask
  always @(posedge clk) rd_seen <= rd_en & ~rst;
  always @(negedge clk) begin
    logic [63:0] e;
    cyc++;
    if (rd_seen) begin
      if (rq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else begin
        e = rq.pop_front();
        chk("rd_data_1", rd_data_1, e[63:32]);
        chk("rd_data_2", rd_data_2, e[31:0]);
      end
    end
    if (dump_valid) begin
      if (dq.size() == 0) chk("dump_unexpected", 32'd1, 32'd0);
      else begin
        chk("dump_addr", {27'd0, dump_addr}, {27'd0, dq[0][36:32]});
        chk("dump_data", dump_data, dq[0][31:0]);
        if (dump_ready) begin
          void'(dq.pop_front());
          acc++;
          if (dump_addr == 5'd0) first_acc = cyc;
          if (dump_addr == 5'd31) last_acc = cyc;
        end
      end
    end
    if (dump_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  initial begin
    repeat (3) step();
    chk("rst_rd1", rd_data_1, 0);
    chk("rst_rd2", rd_data_2, 0);
    chk("rst_flags", {29'd0, dump_valid, dump_busy, dump_done}, 0);
    chk("rst_dump", dump_data | {27'd0, dump_addr}, 0);
    rst = 0;
    step();
    rd(5, 0, 0, 0);
    wr(5, 32'hDEADBEEF);
    rd(5, 0, 32'hDEADBEEF, 0);
    reg_write_en = 1; reg_write_dest = 7; reg_write_data = 32'h12345678;
    rd(7, 7, 32'h12345678, 32'h12345678);
    reg_write_en = 0;
    wr(0, 32'hFFFFFFFF);
    rd(0, 5, 0, 32'hDEADBEEF);
    rd(7, 5, 32'h12345678, 32'hDEADBEEF);
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 17));
    for (int i = 0; i < 32; i++) dq.push_back({5'(i), 32'(i * 17)});
    acc0 = acc;
    dump_ready = 1; dump_start = 1;
    step();
    dump_start = 0;
    chk("busy_start", {31'd0, dump_busy}, 1);
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin
      dump_start = (i == 10);
      step();
    end
    dump_start = 0;
    chk("done_seen", done_cnt, 1);
    chk("accepted", acc - acc0, 32);
    chk("consecutive", last_acc - first_acc, 31);
    chk("done_timing", done_cyc - last_acc, 1);
    chk("after_done", {29'd0, dump_valid, dump_busy, dump_done}, 0);
    for (int i = 0; i <= 10; i++) dq.push_back({5'(i), 32'(i * 17)});
    dump_ready = 1; dump_start = 1;
    step();
    dump_start = 0;
    stall = 0; hit = 0;
    for (int i = 0; i < 100 && hit == 0; i++) begin
      reg_write_en = 0; rd_en = 0; dump_ready = 1;
      if (dump_valid && dump_addr == 5'd10) begin
        dump_ready = 0; rst = 1; hit = 1;
      end else if (dump_valid && dump_addr == 5'd4 && stall < 3) begin
        dump_ready = 0;
        if (stall == 0) begin
          reg_write_en = 1; reg_write_dest = 4; reg_write_data = 32'hAA;
        end
        if (stall == 1) begin
          rd_en = 1; rd_addr_1 = 4; rd_addr_2 = 3;
          rq.push_back({32'hAA, 32'h33});
        end
        stall++;
      end
      step();
    end
    reg_write_en = 0; rd_en = 0;
    chk("reset_hit", hit, 1);
    chk("stall_cycles", stall, 3);
    chk("rst_mid_flags", {30'd0, dump_valid, dump_busy}, 0);
    chk("rst_mid_rd1", rd_data_1, 0);
    dc0 = done_cnt;
    rst = 0; dump_ready = 0;
    repeat (3) step();
    chk("no_done_after_rst", done_cnt, dc0);
    chk("dq_left", dq.size(), 1);
    dq.delete();
    rd(4, 10, 0, 0);
    repeat (3) step();
    chk("rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
